// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop).
//
// Recovers bytes from the asynchronous uart_rxd pin. The start bit is
// qualified at its middle, and every later bit is sampled one full bit period
// after the previous sample, so all samples land mid-bit.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   UART_BPS  baud rate; CLK_FREQ/UART_BPS must lie in 4..65535
//
// Ports
//   I_clk      in   system clock, rising edge
//   I_rst_n    in   synchronous active-low reset
//   uart_rxd   in   asynchronous serial input, idles high
//   uart_data  out  last correctly received byte, held until the next good one
//   uart_done  out  one-cycle pulse when uart_data updates
//   frame_err  out  one-cycle pulse when a stop bit samples 0
//   busy       out  high while a frame is in progress (registered from state)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;

  localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  logic        r_rx_s0;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_ferr;
  logic        r_busy;

  logic        w_fall;

  // r_rx_s2 is only a history copy of the synchronised line, used to find the
  // start-bit falling edge; it is never used for sampling.
  assign w_fall = r_rx_s2 & ~r_rx_s1;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_rx_s0   <= 1'b1;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rx_s0 <= uart_rxd;
      r_rx_s1 <= r_rx_s0;
      r_rx_s2 <= r_rx_s1;

      // Pulses default low; only the STOP exit raises one of them.
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
          end
        end

        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            if (!r_rx_s1) begin
              r_state   <= S_DATA;
              r_clk_cnt <= '0;
              r_bit_cnt <= '0;
            end else begin
              // Line is high again at mid start bit: a glitch, not a frame.
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (r_clk_cnt == BPS_LAST) begin
            r_shift   <= {r_rx_s1, r_shift[7:1]};
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        S_STOP: begin
          // Leaving at mid stop bit lets the next start edge, half a bit
          // later, be caught with no idle gap between frames.
          if (r_clk_cnt == BPS_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
            if (r_rx_s1) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_data = r_data;
  assign uart_done = r_done;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
//
// A fast instance (10 clocks per bit) covers single, back-to-back, glitch,
// framing-error, table-driven, random and mid-frame reset sequences. A second
// instance at the default parameters checks the long-latency case.
// The reference model works at frame level: each frame sent produces one
// expected event (done or frame_err, its data, and the cycle it must appear),
// computed from the frame contents and the start-edge cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BPS     = 10;     // 1 MHz / 100 kbaud
  localparam int LAT     = 98;     // 3 + HALF(5) + 9*BPS(90)
  localparam int DEF_BPS = 5208;   // 50 MHz / 9600
  localparam int DEF_LAT = 49479;  // 3 + 2604 + 9*5208

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_def = 1'b1;
  logic [7:0] uart_data, uart_data_def;
  logic       uart_done, uart_done_def;
  logic       frame_err, frame_err_def;
  logic       busy, busy_def;

  uart_rx #(.CLK_FREQ(1000000), .UART_BPS(100000)) u_dut (
    .I_clk    (clk),
    .I_rst_n  (rst_n),
    .uart_rxd (rxd),
    .uart_data(uart_data),
    .uart_done(uart_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  uart_rx #(.CLK_FREQ(50000000), .UART_BPS(9600)) u_dut_def (
    .I_clk    (clk),
    .I_rst_n  (rst_n),
    .uart_rxd (rxd_def),
    .uart_data(uart_data_def),
    .uart_done(uart_done_def),
    .frame_err(frame_err_def),
    .busy     (busy_def)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       done;
    logic       ferr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
  } vec_t;

  ev_t obs_q[$], exp_q[$], obs_d[$], exp_d[$];
  logic [7:0] last_good = 8'h00;
  int n_checks = 0;
  int n_fail   = 0;

  // Record every cycle in which either pulse is high.
  always @(negedge clk) begin
    if (uart_done || frame_err)
      obs_q.push_back('{cyc, uart_done, frame_err, uart_data});
    if (uart_done_def || frame_err_def)
      obs_d.push_back('{cyc, uart_done_def, frame_err_def, uart_data_def});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n, input bit def);
    tick();
    if (def) rxd_def = b;
    else     rxd = b;
    repeat (n - 1) tick();
  endtask

  task automatic idle(input int n, input bit def);
    if (n > 0) drive_bit(1'b1, n, def);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit def);
    int bps;
    int f;
    bps = def ? DEF_BPS : BPS;
    tick();
    if (def) rxd_def = 1'b0;
    else     rxd = 1'b0;
    f = cyc;
    if (def) begin
      exp_d.push_back('{f + DEF_LAT, 1'b1, 1'b0, b});
    end else if (stop) begin
      exp_q.push_back('{f + LAT, 1'b1, 1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back('{f + LAT, 1'b0, 1'b1, last_good});
    end
    repeat (bps - 1) tick();
    for (int k = 0; k < 8; k++) begin
      drive_bit(b[k], bps, def);
      if (k == 3) check(def ? "busy_mid_frame_def" : "busy_mid_frame", def ? busy_def : busy, 1);
    end
    drive_bit(stop, bps, def);
  endtask

  task automatic compare_events(input string tag, input bit def);
    ev_t o[$];
    ev_t e[$];
    int  n;
    if (def) begin o = obs_d; e = exp_d; obs_d.delete(); exp_d.delete(); end
    else     begin o = obs_q; e = exp_q; obs_q.delete(); exp_q.delete(); end
    check({tag, "_event_count"}, o.size(), e.size());
    n = (o.size() < e.size()) ? o.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d_cycle", tag, i), o[i].cyc,  e[i].cyc);
      check($sformatf("%s_ev%0d_done",  tag, i), o[i].done, e[i].done);
      check($sformatf("%s_ev%0d_ferr",  tag, i), o[i].ferr, e[i].ferr);
      check($sformatf("%s_ev%0d_data",  tag, i), o[i].data, e[i].data);
    end
  endtask

  vec_t tbl [6];
  logic [7:0] held;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 0};
    tbl[1] = '{8'hFF, 1'b1, 3};
    tbl[2] = '{8'h80, 1'b0, 2};
    tbl[3] = '{8'h01, 1'b1, 0};
    tbl[4] = '{8'hC3, 1'b0, 1};
    tbl[5] = '{8'h5A, 1'b1, 7};

    // Reset state
    repeat (3) tick();
    check("reset_data", uart_data, 0);
    check("reset_done", uart_done, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(5, 1'b0);

    // Single frame
    send_frame(8'h55, 1'b1, 1'b0);
    tick();
    check("single_busy_after", busy, 0);
    idle(20, 1'b0);
    compare_events("single", 1'b0);

    // Back-to-back frames, no idle gap
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20, 1'b0);
    if (obs_q.size() >= 2) check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, 100);
    compare_events("b2b", 1'b0);

    // Glitch rejection
    held = uart_data;
    drive_bit(1'b0, 3, 1'b0);
    idle(40, 1'b0);
    check("glitch_busy", busy, 0);
    check("glitch_data_held", uart_data, held);
    compare_events("glitch", 1'b0);

    // Framing error between two good frames
    send_frame(8'h12, 1'b1, 1'b0);
    idle(5, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    idle(5, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    idle(20, 1'b0);
    compare_events("frame_err", 1'b0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, 1'b0);
      idle(tbl[i].gap, 1'b0);
    end
    idle(20, 1'b0);
    compare_events("table", 1'b0);

    // Randomized frames; a bad stop needs a high gap before the next edge
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit s;
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 7) != 0);
      send_frame(b, s, 1'b0);
      idle(s ? $urandom_range(0, 12) : $urandom_range(1, 12), 1'b0);
    end
    idle(20, 1'b0);
    compare_events("random", 1'b0);

    // Reset mid-frame during data bit 3 of 0x81
    send_frame(8'h34, 1'b1, 1'b0);
    idle(10, 1'b0);
    compare_events("pre_reset", 1'b0);
    drive_bit(1'b0, BPS, 1'b0);
    drive_bit(1'b1, BPS, 1'b0);
    drive_bit(1'b0, BPS, 1'b0);
    drive_bit(1'b0, BPS, 1'b0);
    drive_bit(1'b0, 5, 1'b0);
    check("prereset_busy", busy, 1);
    tick();
    rst_n = 1'b0;
    rxd = 1'b1;
    tick();
    check("midreset_data", uart_data, 0);
    check("midreset_done", uart_done, 0);
    check("midreset_ferr", frame_err, 0);
    check("midreset_busy", busy, 0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(30, 1'b0);
    compare_events("reset_abort", 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20, 1'b0);
    compare_events("post_reset", 1'b0);

    // Default parameters: 5208 clocks per bit
    send_frame(8'h00, 1'b1, 1'b1);
    idle(20, 1'b1);
    compare_events("default_params", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
